riscv_test_checker: RTL
=======================

Name: riscv_test_checker

Overview:
Synthesizable, table-driven result checker that monitors the RISCV_TOP retirement interface (NUM_INST, OUTPUT_PORT, HALT). It compares OUTPUT_PORT against a loadable table of expected values keyed by instruction count. It replaces hard-coded per-test bench logic, so the same block serves every test program and can also sit on an FPGA build next to the core. It adds pass/fail counting, missed-checkpoint detection, a stall watchdog and a selectable stop-on-fail mode.

Parameters:
NUM_TEST, 23, number of checkpoint entries in the expectation table
IDX_W, 5, width of table index; 2**IDX_W >= NUM_TEST
TIMEOUT, 100000, cycles NUM_INST may stay unchanged in RUN before a watchdog abort
STOP_ON_FAIL, 1, 1 = enter DONE on the first mismatch; 0 = keep checking to HALT

Ports:
CLK  in  1  clock
RSTn  in  1  reset
TBL_WE  in  1  table write strobe; accepted only in IDLE
TBL_ADDR  in  IDX_W  table entry index
TBL_NUM_INST  in  32  checkpoint instruction count for the entry
TBL_ANS  in  32  expected OUTPUT_PORT for the entry
START  in  1  IDLE->RUN; the core must be released from reset on the same edge
NUM_INST  in  32  retired-instruction count from the core
OUTPUT_PORT  in  32  core result port
HALT  in  1  core halt indication
RUNNING  out  1  state == RUN
DONE  out  1  state == DONE
SUCCESS  out  1  valid when DONE
TIMEOUT_ERR  out  1  watchdog fired
PASS_CNT  out  IDX_W+1  checkpoints passed
FAIL_CNT  out  IDX_W+1  checkpoints failed or missed
FAIL_IDX  out  IDX_W  index of the first failing entry
FAIL_VAL  out  32  OUTPUT_PORT captured at the first failure
CYCLE  out  32  cycles spent in RUN

Behaviour:
- Reset: reset RSTn, synchronous, active-low; clock CLK. While RSTn=0 at a posedge: state=IDLE, ptr=0, all outputs and counters 0, table contents unchanged.
- IDLE:
  - TBL_WE writes {TBL_NUM_INST, TBL_ANS} to entry TBL_ADDR. Writes with TBL_ADDR >= NUM_TEST are ignored.
  - Entries must be loaded in strictly ascending TBL_NUM_INST order. Out-of-order tables are unsupported.
  - START=1 -> RUN on the next edge; counters and ptr clear on that edge.
  - TBL_WE and START in the same cycle: the write completes, then RUN.
- RUN: each cycle, CYCLE increments (wraps at 2^32) and entry E=table[ptr] is evaluated. Priority order:
  1. ptr == NUM_TEST: no compare is made; only HALT and the watchdog are active.
  2. NUM_INST == E.num:
     - OUTPUT_PORT == E.ans -> PASS_CNT++, ptr++.
     - Otherwise -> FAIL_CNT++, ptr++; record FAIL_IDX/FAIL_VAL if this is the first failure.
  3. NUM_INST > E.num (checkpoint skipped, e.g. a retirement step >1): counts as a failure. FAIL_CNT++, ptr++; FAIL_VAL := OUTPUT_PORT if first failure.
  4. Otherwise: no action.
- At most one entry is consumed per cycle. Several skipped entries resolve on consecutive cycles, one per cycle.
- Stop-on-fail: if STOP_ON_FAIL=1 and a failure is recorded, state -> DONE on the same edge.
- HALT:
  - HALT=1 in RUN -> DONE on the next edge.
  - The checkpoint compare for that cycle is still performed; the same-cycle result is counted.
  - Entries remaining unchecked at HALT are not counted as failures but force SUCCESS=0.
- Watchdog:
  - An idle counter resets whenever NUM_INST changes or on entry to RUN.
  - When it reaches TIMEOUT-1 -> TIMEOUT_ERR=1, DONE.
  - HALT takes priority if both occur in the same cycle.
- DONE:
  - Holds until reset; all outputs are frozen and START and TBL_WE are ignored.
  - SUCCESS = (FAIL_CNT==0) && (ptr==NUM_TEST) && !TIMEOUT_ERR. SUCCESS is registered and asserted together with DONE.
- Timing: all outputs are registered. Checkpoint results appear in counters one cycle after the compare cycle.
- Counter widths: PASS_CNT and FAIL_CNT are each bounded by NUM_TEST, so they never overflow.

Test Plan:
- Table load and all-pass:
  - Stimulus: load 23 entries (num=1..23 with the answers 0,0,5,0,1,0,1,5,5,0xF,0x1E,0xF,2,7,2,0x14,0,0,0,0xA,0xA,0x1E,0x14); START; drive NUM_INST 1..23 with matching OUTPUT_PORT, then HALT.
  - Required: PASS_CNT=23, FAIL_CNT=0, DONE=1, SUCCESS=1.
- Mismatch, STOP_ON_FAIL=1:
  - Stimulus: OUTPUT_PORT=0x4 at NUM_INST=3.
  - Required: DONE one edge later, FAIL_IDX=2, FAIL_VAL=0x4, PASS_CNT=2, SUCCESS=0.
- Mismatch, STOP_ON_FAIL=0:
  - Stimulus: mismatches at entries 5 and 10, then HALT after entry 23.
  - Required: FAIL_CNT=2, PASS_CNT=21, FAIL_IDX=5, SUCCESS=0.
- Skipped checkpoint:
  - Stimulus: NUM_INST jumps 6->8.
  - Required: entry 6 (num=7) counted failed on the first cycle, entry 7 (num=8) compared the next cycle; FAIL_IDX=6.
- Watchdog:
  - Stimulus: TIMEOUT=16; hold NUM_INST=4 with no HALT.
  - Required: TIMEOUT_ERR=1 and DONE after 16 RUN cycles with NUM_INST unchanged; SUCCESS=0. HALT asserted the same cycle gives TIMEOUT_ERR=0.
- Reset mid-run and IDLE write guard:
  - Stimulus: assert RSTn=0 during RUN; restart without reloading the table.
  - Required: counters return to 0 and the same table passes again. A TBL_WE pulse during RUN does not alter the table.

Source files
------------

// File: rtl/riscv_test_checker_if.sv
// Bundles the checker's table-load, core-monitor and status signals.
// The driver (bench or SoC glue) takes the master side. The checker takes the slave side.
interface riscv_test_checker_if #(
    parameter int IDX_W = 5
);
    logic             TBL_WE;
    logic [IDX_W-1:0] TBL_ADDR;
    logic [31:0]      TBL_NUM_INST;
    logic [31:0]      TBL_ANS;
    logic             START;
    logic [31:0]      NUM_INST;
    logic [31:0]      OUTPUT_PORT;
    logic             HALT;

    logic             RUNNING;
    logic             DONE;
    logic             SUCCESS;
    logic             TIMEOUT_ERR;
    logic [IDX_W:0]   PASS_CNT;
    logic [IDX_W:0]   FAIL_CNT;
    logic [IDX_W-1:0] FAIL_IDX;
    logic [31:0]      FAIL_VAL;
    logic [31:0]      CYCLE;

    modport master (
        output TBL_WE, TBL_ADDR, TBL_NUM_INST, TBL_ANS,
        output START, NUM_INST, OUTPUT_PORT, HALT,
        input  RUNNING, DONE, SUCCESS, TIMEOUT_ERR,
        input  PASS_CNT, FAIL_CNT, FAIL_IDX, FAIL_VAL, CYCLE
    );

    modport slave (
        input  TBL_WE, TBL_ADDR, TBL_NUM_INST, TBL_ANS,
        input  START, NUM_INST, OUTPUT_PORT, HALT,
        output RUNNING, DONE, SUCCESS, TIMEOUT_ERR,
        output PASS_CNT, FAIL_CNT, FAIL_IDX, FAIL_VAL, CYCLE
    );
endinterface

// File: rtl/riscv_test_checker.sv
// Table-driven retirement checker: compares OUTPUT_PORT against expected values at given
// NUM_INST checkpoints, with pass/fail counting, skipped-checkpoint detection and a stall watchdog.
module riscv_test_checker #(
    parameter int NUM_TEST     = 23,
    parameter int IDX_W        = 5,
    parameter int TIMEOUT      = 100000,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input logic                  CLK,
    input logic                  RSTn,
    riscv_test_checker_if.slave  bus
);
    localparam int                PTR_W   = IDX_W + 1;
    localparam logic [PTR_W-1:0]  END_PTR = PTR_W'(NUM_TEST);
    localparam logic [31:0]       WD_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] pass_cnt;
    logic [PTR_W-1:0] fail_cnt;
    logic [IDX_W-1:0] fail_idx;
    logic [31:0]      fail_val;
    logic [31:0]      cycle_cnt;
    logic [31:0]      idle_cnt;
    logic [31:0]      prev_num;
    logic             running_q;
    logic             done_q;
    logic             success_q;
    logic             timeout_q;

    // NOTE: the expectation table has no reset so it survives RSTn and can map onto RAM.
    logic [31:0] tbl_num [NUM_TEST];
    logic [31:0] tbl_ans [NUM_TEST];

    always_ff @(posedge CLK) begin
        if (RSTn && state == ST_IDLE && bus.TBL_WE && ({1'b0, bus.TBL_ADDR} < END_PTR)) begin
            tbl_num[bus.TBL_ADDR] <= bus.TBL_NUM_INST;
            tbl_ans[bus.TBL_ADDR] <= bus.TBL_ANS;
        end
    end

    logic [IDX_W-1:0] ptr_idx;
    logic [31:0]      ent_num;
    logic [31:0]      ent_ans;
    logic             pass_now;
    logic             fail_now;
    logic             stall;
    logic             wd_fire;
    logic             stop_now;
    logic             wd_abort;
    logic             finish_now;
    logic [PTR_W-1:0] pass_nx;
    logic [PTR_W-1:0] fail_nx;
    logic [PTR_W-1:0] ptr_nx;

    assign ptr_idx = ptr[IDX_W-1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ent_num  = '0;
        ent_ans  = '0;
        pass_now = 1'b0;
        fail_now = 1'b0;
        if (state == ST_RUN && ptr != END_PTR) begin
            ent_num = tbl_num[ptr_idx];
            ent_ans = tbl_ans[ptr_idx];
            if (bus.NUM_INST == ent_num) begin
                pass_now = (bus.OUTPUT_PORT == ent_ans);
                fail_now = (bus.OUTPUT_PORT != ent_ans);
            end else if (bus.NUM_INST > ent_num) begin
                fail_now = 1'b1;
            end
        end

        stall      = (bus.NUM_INST == prev_num);
        wd_fire    = stall && (idle_cnt == WD_LAST);
        stop_now   = STOP_ON_FAIL && fail_now;
        wd_abort   = wd_fire && !bus.HALT && !stop_now;
        finish_now = bus.HALT || stop_now || wd_fire;

        pass_nx = pass_cnt + PTR_W'(pass_now);
        fail_nx = fail_cnt + PTR_W'(fail_now);
        ptr_nx  = ptr + PTR_W'(pass_now || fail_now);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_idx  <= '0;
            fail_val  <= '0;
            cycle_cnt <= '0;
            idle_cnt  <= '0;
            prev_num  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            success_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.START) begin
                        state     <= ST_RUN;
                        running_q <= 1'b1;
                        ptr       <= '0;
                        pass_cnt  <= '0;
                        fail_cnt  <= '0;
                        fail_idx  <= '0;
                        fail_val  <= '0;
                        cycle_cnt <= '0;
                        idle_cnt  <= '0;
                        prev_num  <= bus.NUM_INST;
                    end
                end

                ST_RUN: begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                    pass_cnt  <= pass_nx;
                    fail_cnt  <= fail_nx;
                    ptr       <= ptr_nx;
                    prev_num  <= bus.NUM_INST;
                    idle_cnt  <= stall ? idle_cnt + 32'd1 : '0;

                    // Only the first failure is captured for post-mortem.
                    if (fail_now && fail_cnt == '0) begin
                        fail_idx <= ptr_idx;
                        fail_val <= bus.OUTPUT_PORT;
                    end

                    if (finish_now) begin
                        state     <= ST_DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= wd_abort;
                        success_q <= (fail_nx == '0) && (ptr_nx == END_PTR) && !wd_abort;
                    end
                end

                ST_DONE: begin
                    state <= ST_DONE;
                end

                default: begin
                    state     <= ST_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.RUNNING     = running_q;
    assign bus.DONE        = done_q;
    assign bus.SUCCESS     = success_q;
    assign bus.TIMEOUT_ERR = timeout_q;
    assign bus.PASS_CNT    = pass_cnt;
    assign bus.FAIL_CNT    = fail_cnt;
    assign bus.FAIL_IDX    = fail_idx;
    assign bus.FAIL_VAL    = fail_val;
    assign bus.CYCLE       = cycle_cnt;
endmodule
